// File: rtl/input_front_end_pkg.sv
// Shared definitions for the board input front end: entry FSM states and KEY bit roles.
package input_front_end_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GOT_AMOUNT = 2'd1,
    READY      = 2'd2
  } fe_state_t;

  localparam int NUM_KEYS   = 4;
  localparam int SW_WIDTH   = 10;
  localparam int KEY_START  = 0;
  localparam int KEY_LOAD   = 1;
  localparam int KEY_UNUSED = 2;
  localparam int KEY_CANCEL = 3;

endpackage

// File: rtl/input_front_end_key_debounce.sv
// Debouncer for one synchronized active-low KEY line; emits a one-cycle pulse per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic level_sync_n,
  output logic level_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: state lives in always_ff with non-blocking updates and an async reset
  // branch, so every flop samples the same pre-edge values with no ordering races.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level_n <= 1'b1;
      count   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (level_sync_n == level_n) begin
        count <= '0;
      end else if (count == LAST) begin
        level_n <= level_sync_n;
        count   <= '0;
        press   <= ~level_sync_n;   // only the 1->0 acceptance is a press
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_front_end.sv
// Board input front end: KEY/SW synchronization, debouncing and amount/key/player entry FSM.
// Optional KEY[0] auto-repeat is enabled by defining INPUT_FRONT_END_AUTOREPEAT_EN.
module input_front_end
  import input_front_end_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                start_pulse,
  output logic [7:0]          amount_out,
  output logic [7:0]          key_out,
  output logic                player_out,
  output logic                entry_valid,
  input  logic                entry_ready
);

  logic [NUM_KEYS-1:0] key_meta, key_sync;
  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic [NUM_KEYS-1:0] level_n, press;
  fe_state_t           state;

  // Keys idle high (released) out of reset so no phantom press is seen.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clock        (clock),
      .resetn       (resetn),
      .level_sync_n (key_sync[i]),
      .level_n      (level_n[i]),
      .press        (press[i])
    );
  end

`ifdef INPUT_FRONT_END_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] repeat_count;
  logic          repeat_pulse;

  // Counter restarts whenever the key is released, so repeats are phased to the initial press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      repeat_count <= '0;
      repeat_pulse <= 1'b0;
    end else if (level_n[KEY_START]) begin
      repeat_count <= '0;
      repeat_pulse <= 1'b0;
    end else if (repeat_count == REPEAT_LAST) begin
      repeat_count <= '0;
      repeat_pulse <= 1'b1;
    end else begin
      repeat_count <= repeat_count + 1'b1;
      repeat_pulse <= 1'b0;
    end
  end

  assign start_pulse = press[KEY_START] | repeat_pulse;
`else
  assign start_pulse = press[KEY_START];
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      amount_out  <= '0;
      key_out     <= '0;
      player_out  <= 1'b0;
      entry_valid <= 1'b0;
    end else if (press[KEY_CANCEL]) begin
      state       <= IDLE;
      amount_out  <= '0;
      key_out     <= '0;
      player_out  <= 1'b0;
      entry_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press[KEY_LOAD]) begin
            amount_out <= sw_sync[7:0];
            player_out <= sw_sync[8];
            state      <= GOT_AMOUNT;
          end
        end
        GOT_AMOUNT: begin
          if (press[KEY_LOAD]) begin
            key_out     <= sw_sync[7:0];
            entry_valid <= 1'b1;
            state       <= READY;
          end
        end
        READY: begin
          if (entry_ready) begin
            entry_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          entry_valid <= 1'b0;
        end
      endcase
    end
  end

  logic unused;
  assign unused = ^{sw_sync[9], press[KEY_UNUSED], level_n, REPEAT_CYCLES[0]};

endmodule

// File: tb/tb_input_front_end.sv
// Scoreboard bench for input_front_end: expected pulses/bundles queued at stimulus, checked by a monitor.
module tb_input_front_end;

  localparam int DC  = 4;
  localparam int RC  = 16;
  localparam int LAT = 2 + DC;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic       entry_ready;
  logic       start_pulse;
  logic [7:0] amount_out;
  logic [7:0] key_out;
  logic       player_out;
  logic       entry_valid;

  input_front_end #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_CYCLES   (RC)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .key_n       (key_n),
    .sw          (sw),
    .start_pulse (start_pulse),
    .amount_out  (amount_out),
    .key_out     (key_out),
    .player_out  (player_out),
    .entry_valid (entry_valid),
    .entry_ready (entry_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] amt;
    logic [7:0] key;
    logic       pl;
  } entry_t;

  int     pulse_q[$];
  entry_t entry_q[$];

  // Reference model of the entry sequence: 0 = waiting amount, 1 = waiting key, 2 = complete.
  int         m_state;
  logic [7:0] m_amt, m_key;
  logic       m_pl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_clear();
    m_state = 0;
    m_amt   = '0;
    m_key   = '0;
    m_pl    = 1'b0;
  endtask

  task automatic model_load();
    entry_t e;
    if (m_state == 0) begin
      m_amt   = sw[7:0];
      m_pl    = sw[8];
      m_state = 1;
    end else if (m_state == 1) begin
      m_key   = sw[7:0];
      m_state = 2;
      e.amt = m_amt; e.key = m_key; e.pl = m_pl;
      entry_q.push_back(e);
    end
  endtask

  // A press held for 'hold' cycles: first pulse LAT later, repeats every RC while still held.
  task automatic expect_start(input int t0, input int hold);
`ifdef INPUT_FRONT_END_AUTOREPEAT_EN
    for (int k = 0; RC * k < hold; k++) pulse_q.push_back(t0 + LAT + RC * k);
`else
    pulse_q.push_back(t0 + LAT);
`endif
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    int t0;
    key_n = key_n & ~mask;
    t0 = cyc;
    if (mask[0]) expect_start(t0, hold);
    if (mask[3]) model_clear();
    else if (mask[1]) model_load();
    tick(hold);
    key_n = key_n | mask;
    tick(LAT + 4);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_amount"}, 32'(amount_out), 32'(m_amt));
    check({tag, "_key"},    32'(key_out),    32'(m_key));
    check({tag, "_player"}, 32'(player_out), 32'(m_pl));
    check({tag, "_valid"},  32'(entry_valid), 32'(m_state == 2));
  endtask

  task automatic pulse_ready();
    entry_ready = 1'b1;
    tick(1);
    entry_ready = 1'b0;
    if (m_state == 2) m_state = 0;
  endtask

  // Monitor: compares every start pulse and every newly presented bundle against the queues.
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
        check("start_pulse_missing", 32'(pulse_q[0]), 32'(-1));
        void'(pulse_q.pop_front());
      end
      if (start_pulse === 1'b1) begin
        if (pulse_q.size() == 0) check("start_pulse_unexpected", 32'(cyc), 32'(-1));
        else check("start_pulse_cycle", 32'(cyc), 32'(pulse_q.pop_front()));
      end
      if (entry_valid === 1'b1 && !prev_valid) begin
        if (entry_q.size() == 0) begin
          check("entry_unexpected", 32'(1), 32'(0));
        end else begin
          entry_t e;
          e = entry_q.pop_front();
          check("entry_amount", 32'(amount_out), 32'(e.amt));
          check("entry_key",    32'(key_out),    32'(e.key));
          check("entry_player", 32'(player_out), 32'(e.pl));
        end
      end
    end
    prev_valid = (entry_valid === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int t0;
    resetn      = 1'b0;
    key_n       = 4'hF;
    sw          = '0;
    entry_ready = 1'b0;
    model_clear();
    tick(3);
    check("reset_start_pulse", 32'(start_pulse), 32'(0));
    check_outputs("reset");
    resetn = 1'b1;
    tick(3);

    // Clean KEY[0] press held 20 cycles: one pulse LAT after the edge, none on release.
    press(4'b0001, 20);

    // Bouncing KEY[1] must not advance the FSM until it settles low.
    sw = 10'h12A;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_n[1] = 1'b0;
    check("bounce_no_advance", 32'(amount_out), 32'(0));
    model_load();
    tick(10);
    key_n[1] = 1'b1;
    tick(LAT + 4);
    check_outputs("after_bounce");

    sw = 10'h0B7;
    press(4'b0010, 8);
    check_outputs("ready");

    // Loads in READY are ignored.
    sw = 10'h055;
    press(4'b0010, 8);
    check_outputs("ready_ignore_load");

    pulse_ready();
    check_outputs("accepted");

    // Cancel and load on the same cycle: cancel wins.
    sw = 10'h1C3;
    press(4'b0010, 8);
    check_outputs("got_amount");
    press(4'b1010, 8);
    check_outputs("cancel_wins");

    // Reset in the middle of an entry clears outputs asynchronously.
    sw = 10'h1FF;
    press(4'b0010, 8);
    resetn = 1'b0;
    #1;
    model_clear();
    check_outputs("async_reset");
    tick(2);

    // Key held through reset release is accepted LAT cycles later.
    key_n[0] = 1'b0;
    tick(1);
    resetn = 1'b1;
    t0 = cyc;
    expect_start(t0, 12);
    tick(12);
    key_n[0] = 1'b1;
    tick(LAT + 4);

    // Randomized mix of loads, cancels, starts, the unused key and stray entry_ready.
    for (int n = 0; n < 24; n++) begin
      int act;
      sw  = 10'($urandom);
      act = $urandom_range(0, 5);
      tick($urandom_range(1, 4));
      case (act)
        0:       press(4'b0001, $urandom_range(8, 40));
        1, 2:    press(4'b0010, $urandom_range(6, 12));
        3:       press(4'b1000, $urandom_range(6, 12));
        4:       press(4'b0100, $urandom_range(6, 12));
        default: pulse_ready();
      endcase
      tick(1);
      check_outputs("random");
    end

    tick(2 * RC + 10);
    check("pulse_queue_drained", 32'(pulse_q.size()), 32'(0));
    check("entry_queue_drained", 32'(entry_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
